// File: rtl/bus_err_drain_ctrl_if.sv
// Bus error unit bank and report port bundle for bus_err_drain_ctrl.
// The master modport is the drain controller side; slave is the unit bank plus report consumer.
interface bus_err_drain_ctrl_if #(
  parameter int unsigned NumUnits      = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned ErrBits       = 3
);
  localparam int unsigned SrcWidth = (NumUnits > 1) ? $clog2(NumUnits) : 1;

  logic [NumUnits-1:0]               unit_err_irq_i;
  logic [NumUnits*ErrBits-1:0]       unit_err_code_i;
  logic [NumUnits*AddrWidth-1:0]     unit_err_addr_i;
  logic [NumUnits*MetaDataWidth-1:0] unit_err_meta_i;
  logic [NumUnits-1:0]               unit_overflow_i;
  logic [NumUnits-1:0]               unit_pop_o;

  logic                     rep_valid_o;
  logic                     rep_ready_i;
  logic [SrcWidth-1:0]      rep_src_o;
  logic [ErrBits-1:0]       rep_code_o;
  logic [AddrWidth-1:0]     rep_addr_o;
  logic [MetaDataWidth-1:0] rep_meta_o;
  logic                     rep_overflow_o;

  modport master (
    input  unit_err_irq_i, unit_err_code_i, unit_err_addr_i, unit_err_meta_i, unit_overflow_i,
    input  rep_ready_i,
    output unit_pop_o,
    output rep_valid_o, rep_src_o, rep_code_o, rep_addr_o, rep_meta_o, rep_overflow_o
  );

  modport slave (
    output unit_err_irq_i, unit_err_code_i, unit_err_addr_i, unit_err_meta_i, unit_overflow_i,
    output rep_ready_i,
    input  unit_pop_o,
    input  rep_valid_o, rep_src_o, rep_code_o, rep_addr_o, rep_meta_o, rep_overflow_o
  );
endinterface

// File: rtl/bus_err_drain_ctrl.sv
// Round-robin drain controller sharing one error report channel between bus error units.
// Define BUS_ERR_DRAIN_CNT_EN to add per-unit saturating capture counters.
module bus_err_drain_ctrl #(
  parameter int unsigned NumUnits      = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned ErrBits       = 3
`ifdef BUS_ERR_DRAIN_CNT_EN
  ,
  parameter int unsigned CntWidth      = 8
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  bus_err_drain_ctrl_if.master        bus_io
`ifdef BUS_ERR_DRAIN_CNT_EN
  ,
  input  logic                        cnt_clear_i,
  output logic [NumUnits*CntWidth-1:0] err_cnt_o
`endif
);
  localparam int unsigned SrcWidth = (NumUnits > 1) ? $clog2(NumUnits) : 1;

  typedef enum logic [0:0] {StIdle, StReport} state_e;

  state_e                   state_q;
  logic [SrcWidth-1:0]      rr_ptr_q, src_q;
  logic [NumUnits-1:0]      ovf_q, ovf_d;
  logic [ErrBits-1:0]       code_q;
  logic [AddrWidth-1:0]     addr_q;
  logic [MetaDataWidth-1:0] meta_q;
  logic                     rep_ovf_q;

  logic                     grant_found, grant_ovf, capture;
  logic [SrcWidth-1:0]      grant_idx, rr_ptr_next;
  logic [NumUnits-1:0]      grant_oh, pop;
  logic [ErrBits-1:0]       grant_code;
  logic [AddrWidth-1:0]     grant_addr;
  logic [MetaDataWidth-1:0] grant_meta;

  // Pass 0 searches indices at or above rr_ptr, pass 1 wraps around from index 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    grant_code  = '0;
    grant_addr  = '0;
    grant_meta  = '0;
    grant_ovf   = 1'b0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < NumUnits; i++) begin
        if (!grant_found && bus_io.unit_err_irq_i[i] &&
            (pass == 1 || SrcWidth'(i) >= rr_ptr_q)) begin
          grant_found = 1'b1;
          grant_idx   = SrcWidth'(i);
          grant_oh[i] = 1'b1;
          grant_code  = bus_io.unit_err_code_i[i*ErrBits +: ErrBits];
          grant_addr  = bus_io.unit_err_addr_i[i*AddrWidth +: AddrWidth];
          grant_meta  = bus_io.unit_err_meta_i[i*MetaDataWidth +: MetaDataWidth];
          grant_ovf   = ovf_q[i];
        end
      end
    end
  end

  // Pop is withheld during reset so a discarded capture cannot consume a FIFO entry.
  assign capture     = (state_q == StIdle) && grant_found && !rst_i;
  assign pop         = capture ? grant_oh : '0;
  assign rr_ptr_next = (grant_idx == SrcWidth'(NumUnits - 1)) ? '0 : grant_idx + 1'b1;
  // A same-cycle overflow re-arms the latch even as its capture clears it.
  assign ovf_d       = (ovf_q & ~pop) | bus_io.unit_overflow_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      ovf_q     <= '0;
      src_q     <= '0;
      code_q    <= '0;
      addr_q    <= '0;
      meta_q    <= '0;
      rep_ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            src_q     <= grant_idx;
            code_q    <= grant_code;
            addr_q    <= grant_addr;
            meta_q    <= grant_meta;
            rep_ovf_q <= grant_ovf;
            rr_ptr_q  <= rr_ptr_next;
            state_q   <= StReport;
          end
        end
        StReport: begin
          if (bus_io.rep_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.unit_pop_o     = pop;
  assign bus_io.rep_valid_o    = (state_q == StReport);
  assign bus_io.rep_src_o      = src_q;
  assign bus_io.rep_code_o     = code_q;
  assign bus_io.rep_addr_o     = addr_q;
  assign bus_io.rep_meta_o     = meta_q;
  assign bus_io.rep_overflow_o = rep_ovf_q;

`ifdef BUS_ERR_DRAIN_CNT_EN
  logic [NumUnits-1:0][CntWidth-1:0] cnt_q;

  // Clear takes priority over a same-cycle capture.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clear_i) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumUnits; i++) begin
        if (pop[i] && (cnt_q[i] != {CntWidth{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign err_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_bus_err_drain_ctrl.sv
// Self-checking bench for bus_err_drain_ctrl: directed scenarios plus randomized traffic
// compared against a queue-level reference model of the unit FIFOs and report port.
module tb_bus_err_drain_ctrl;
  localparam int unsigned NumUnits = 4, AddrWidth = 48, MetaDataWidth = 1, ErrBits = 3;
  localparam int unsigned Depth = 8;
`ifdef BUS_ERR_DRAIN_CNT_EN
  localparam int unsigned CntWidth = 2;
  logic                          cnt_clear;
  logic [NumUnits*CntWidth-1:0]  err_cnt;
`endif

  typedef struct packed {
    logic [ErrBits-1:0]       code;
    logic [AddrWidth-1:0]     addr;
    logic [MetaDataWidth-1:0] meta;
  } entry_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  bus_err_drain_ctrl_if #(.NumUnits(NumUnits), .AddrWidth(AddrWidth),
                          .MetaDataWidth(MetaDataWidth), .ErrBits(ErrBits)) bus ();

  bus_err_drain_ctrl #(
    .NumUnits(NumUnits), .AddrWidth(AddrWidth), .MetaDataWidth(MetaDataWidth), .ErrBits(ErrBits)
`ifdef BUS_ERR_DRAIN_CNT_EN
    , .CntWidth(CntWidth)
`endif
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus_io(bus)
`ifdef BUS_ERR_DRAIN_CNT_EN
    , .cnt_clear_i(cnt_clear),
    .err_cnt_o(err_cnt)
`endif
  );

  // Unit FIFO contents (owned by the bench) and reference model state.
  entry_t mem [NumUnits][Depth];
  int     fcnt [NumUnits];
  bit     m_busy;
  int     m_src, m_ptr;
  entry_t m_ent;
  bit     m_ovf;
  bit     m_ovf_seen [NumUnits];
  int     m_cnt [NumUnits];

  int total, bad, cyc, push_pct;
  logic [NumUnits-1:0] last_pop;
  int pop_src_log[$], pop_cyc_log[$], ovf_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int u, input logic [ErrBits-1:0] c, input logic [AddrWidth-1:0] a,
                      input logic [MetaDataWidth-1:0] m);
    if (fcnt[u] < Depth) begin
      mem[u][fcnt[u]] = '{code: c, addr: a, meta: m};
      fcnt[u]++;
    end
  endtask

  task automatic flush();
    for (int u = 0; u < NumUnits; u++) fcnt[u] = 0;
  endtask

  task automatic cycle(input bit rst, input bit rdy, input logic [NumUnits-1:0] ovf,
                       input bit clr);
    int win;
    int k;
    logic [NumUnits-1:0] exp_pop;
    @(negedge clk_i);
    rst_i = rst;
    bus.rep_ready_i = rdy;
    bus.unit_overflow_i = ovf;
`ifdef BUS_ERR_DRAIN_CNT_EN
    cnt_clear = clr;
`endif
    for (int u = 0; u < NumUnits; u++) begin
      bus.unit_err_irq_i[u] = (fcnt[u] > 0);
      bus.unit_err_code_i[u*ErrBits +: ErrBits] = mem[u][0].code;
      bus.unit_err_addr_i[u*AddrWidth +: AddrWidth] = mem[u][0].addr;
      bus.unit_err_meta_i[u*MetaDataWidth +: MetaDataWidth] = mem[u][0].meta;
    end
    #1;
    // Reference: first non-empty unit scanning upward from the pointer, modulo NumUnits.
    win = -1;
    if (!m_busy && !rst) begin
      for (int j = 0; j < NumUnits; j++) begin
        k = (m_ptr + j) % NumUnits;
        if (win < 0 && fcnt[k] > 0) win = k;
      end
    end
    exp_pop = '0;
    if (win >= 0) exp_pop[win] = 1'b1;
    last_pop = bus.unit_pop_o;
    check("pop", bus.unit_pop_o, exp_pop);
    check("valid", bus.rep_valid_o, m_busy);
    if (m_busy) begin
      check("src", bus.rep_src_o, m_src);
      check("code", bus.rep_code_o, m_ent.code);
      check("addr", bus.rep_addr_o, m_ent.addr);
      check("meta", bus.rep_meta_o, m_ent.meta);
      check("ovf", bus.rep_overflow_o, m_ovf);
      if (rdy && !rst && m_src == 1) ovf_log.push_back(int'(bus.rep_overflow_o));
    end
`ifdef BUS_ERR_DRAIN_CNT_EN
    for (int u = 0; u < NumUnits; u++)
      check("cnt", err_cnt[u*CntWidth +: CntWidth], m_cnt[u]);
`endif
    for (int u = 0; u < NumUnits; u++) begin
      if (bus.unit_pop_o[u]) begin
        pop_src_log.push_back(u);
        pop_cyc_log.push_back(cyc);
      end
    end
    @(posedge clk_i);
    cyc++;
    if (rst) begin
      m_busy = 0;
      m_ptr = 0;
      for (int u = 0; u < NumUnits; u++) begin
        m_ovf_seen[u] = 0;
        m_cnt[u] = 0;
      end
    end else begin
      if (m_busy && rdy) begin
        m_busy = 0;
      end else if (win >= 0) begin
        m_busy = 1;
        m_src = win;
        m_ent = mem[win][0];
        m_ovf = m_ovf_seen[win];
        m_ovf_seen[win] = 0;
        m_ptr = (win + 1) % NumUnits;
        if (!clr && m_cnt[win] < (1 << 2) - 1) m_cnt[win]++;
        for (int j = 0; j < Depth - 1; j++) mem[win][j] = mem[win][j+1];
        fcnt[win]--;
      end
      for (int u = 0; u < NumUnits; u++) begin
        if (ovf[u]) m_ovf_seen[u] = 1;
        if (clr) m_cnt[u] = 0;
      end
    end
    for (int u = 0; u < NumUnits; u++) begin
      if ($urandom_range(99) < push_pct)
        push(u, 3'($urandom), {16'($urandom), $urandom}, 1'($urandom));
    end
  endtask

  initial begin
    int rr_exp [5];
    int npops;
    logic [NumUnits-1:0] rovf;
    rr_exp = '{0, 1, 2, 3, 0};
    total = 0; bad = 0; cyc = 0; push_pct = 0;
    m_busy = 0; m_ptr = 0; m_src = 0; m_ovf = 0; m_ent = '0;
    for (int u = 0; u < NumUnits; u++) begin
      fcnt[u] = 0; m_ovf_seen[u] = 0; m_cnt[u] = 0;
      for (int j = 0; j < Depth; j++) mem[u][j] = '0;
    end
    bus.unit_err_irq_i = '0; bus.unit_err_code_i = '0; bus.unit_err_addr_i = '0;
    bus.unit_err_meta_i = '0; bus.unit_overflow_i = '0; bus.rep_ready_i = 1'b0;
`ifdef BUS_ERR_DRAIN_CNT_EN
    cnt_clear = 1'b0;
`endif

    // Reset state.
    cycle(1, 0, '0, 0);
    cycle(1, 0, '0, 0);
    #1;
    check("rst_valid", bus.rep_valid_o, 0);
    check("rst_src", bus.rep_src_o, 0);
    check("rst_code", bus.rep_code_o, 0);
    check("rst_addr", bus.rep_addr_o, 0);
    check("rst_meta", bus.rep_meta_o, 0);
    check("rst_ovf", bus.rep_overflow_o, 0);

    // Single error from unit 2.
    push(2, 3'h5, 48'h1000, 1'b1);
    cycle(0, 0, '0, 0);
    check("single_pop", last_pop, 4'b0100);
    #1;
    check("single_valid", bus.rep_valid_o, 1);
    check("single_src", bus.rep_src_o, 2);
    check("single_code", bus.rep_code_o, 5);
    check("single_addr", bus.rep_addr_o, 48'h1000);
    check("single_meta", bus.rep_meta_o, 1);
    cycle(0, 1, '0, 0);

    // Round-robin with all units pending and ready held high.
    cycle(1, 0, '0, 0);
    pop_src_log.delete(); pop_cyc_log.delete();
    for (int u = 0; u < NumUnits; u++)
      for (int j = 0; j < 3; j++) push(u, 3'(u + j), 48'(u * 16 + j), 1'(j));
    repeat (10) cycle(0, 1, '0, 0);
    check("rr_count", pop_src_log.size(), 5);
    for (int i = 0; i < 5 && i < pop_src_log.size(); i++) begin
      check("rr_src", pop_src_log[i], rr_exp[i]);
      if (i > 0) check("rr_spacing", pop_cyc_log[i] - pop_cyc_log[i-1], 2);
    end

    // Backpressure: report held, no pops, then release.
    flush();
    cycle(1, 0, '0, 0);
    push(1, 3'h2, 48'hABCD_0000_1234, 1'b0);
    push(3, 3'h7, 48'h0000_FFFF_0000, 1'b1);
    cycle(0, 0, '0, 0);
    check("bp_first_pop", last_pop, 4'b0010);
    npops = pop_src_log.size();
    repeat (10) cycle(0, 0, '0, 0);
    check("bp_no_pop", pop_src_log.size(), npops);
    cycle(0, 1, '0, 0);
    cycle(0, 0, '0, 0);
    check("bp_next_pop", last_pop, 4'b1000);
    cycle(0, 1, '0, 0);

    // Overflow latch on unit 1.
    flush();
    cycle(1, 0, '0, 0);
    ovf_log.delete();
    cycle(0, 0, 4'b0010, 0);
    push(1, 3'h1, 48'h10, 1'b0);
    push(1, 3'h3, 48'h20, 1'b1);
    repeat (8) cycle(0, 1, '0, 0);
    check("ovf_reports", ovf_log.size(), 2);
    if (ovf_log.size() == 2) begin
      check("ovf_first", ovf_log[0], 1);
      check("ovf_second", ovf_log[1], 0);
    end

    // Reset while a report is held.
    flush();
    cycle(1, 0, '0, 0);
    push(2, 3'h4, 48'h40, 1'b0);
    cycle(0, 0, '0, 0);
    push(1, 3'h6, 48'h60, 1'b1);
    push(3, 3'h2, 48'h80, 1'b0);
    cycle(1, 0, '0, 0);
    check("rstmid_pop", last_pop, 4'b0000);
    #1;
    check("rstmid_valid", bus.rep_valid_o, 0);
    cycle(0, 0, '0, 0);
    check("rstmid_ptr", last_pop, 4'b0010);
    cycle(0, 1, '0, 0);

    // Randomized traffic with occasional reset, overflow and counter clear.
    flush();
    cycle(1, 0, '0, 0);
    push_pct = 25;
    repeat (400) begin
      for (int u = 0; u < NumUnits; u++) rovf[u] = ($urandom_range(99) < 5);
      cycle($urandom_range(199) == 0, $urandom_range(99) < 60, rovf, $urandom_range(99) < 3);
    end
    push_pct = 0;

`ifdef BUS_ERR_DRAIN_CNT_EN
    // Counter saturation and clear priority.
    flush();
    cycle(1, 0, '0, 0);
    for (int j = 0; j < 5; j++) push(0, 3'(j), 48'(j), 1'b0);
    repeat (12) cycle(0, 1, '0, 0);
    #1;
    check("cnt_sat", err_cnt[CntWidth-1:0], 3);
    push(0, 3'h1, 48'h1, 1'b1);
    cycle(0, 0, '0, 1);
    check("cnt_clr_pop", last_pop, 4'b0001);
    #1;
    check("cnt_clr", err_cnt[CntWidth-1:0], 0);
    cycle(0, 1, '0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
